// File: rtl/bin_conv_pe_if.sv
// Activation stream in, result stream out: both valid/ready handshakes of the binary conv PE.
// master = producer/consumer side (fetch + writer), slave = the PE itself.
interface bin_conv_pe_if #(
    parameter int ADDR_W = 12,
    parameter int IDX_W  = 4,
    parameter int SUM_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              data_in;
    logic [ADDR_W-1:0] write_addr_in;
    logic [IDX_W-1:0]  idx_in;

    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  sum_out;
    logic              negative_flag;
    logic [ADDR_W-1:0] write_addr_out;
    logic [IDX_W-1:0]  idx_out;

    modport master (
        output in_valid, data_in, write_addr_in, idx_in, out_ready,
        input  in_ready, out_valid, sum_out, negative_flag, write_addr_out, idx_out
    );

    modport slave (
        input  in_valid, data_in, write_addr_in, idx_in, out_ready,
        output in_ready, out_valid, sum_out, negative_flag, write_addr_out, idx_out
    );
endinterface

// File: rtl/bin_conv_pe.sv
// Binary (XNOR-style) convolution PE: counts weight/activation sign mismatches over TAPS taps
// and emits TAPS - 2*mismatches with the sideband captured at tap 0.
module bin_conv_pe #(
    parameter  int TAPS   = 9,
    parameter  int ADDR_W = 12,
    parameter  int IDX_W  = 4,
    localparam int CNT_W  = $clog2(TAPS + 1),
    localparam int SUM_W  = CNT_W + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          go,
    input  logic          clear,
    input  logic          load_weight,
    input  logic          weight_in,
    bin_conv_pe_if.slave  bus
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state_q, state_d;
    logic [TAPS-1:0]   kernel_q, kernel_d;
    logic [CNT_W-1:0]  tap_cnt_q, tap_cnt_d;
    logic [CNT_W-1:0]  mism_q, mism_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [IDX_W-1:0]  idx_sh_q, idx_sh_d;
    logic              out_valid_q, out_valid_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              neg_q, neg_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [IDX_W-1:0]  idx_out_q, idx_out_d;

    logic              accept;
    logic              last_tap;
    logic              tap_xor;
    logic [TAPS-1:0]   kernel_aligned;
    logic [CNT_W-1:0]  mism_total;
    logic [SUM_W-1:0]  twice_mism;

    assign bus.in_ready       = go & ~clear & ~(out_valid_q & ~bus.out_ready);
    assign accept             = bus.in_valid & bus.in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.sum_out        = sum_q;
    assign bus.negative_flag  = neg_q;
    assign bus.write_addr_out = addr_out_q;
    assign bus.idx_out        = idx_out_q;

    // The first loaded weight ends up in the MSB, so shifting left by the tap index
    // brings the weight for the current tap to the MSB.
    assign kernel_aligned = kernel_q << tap_cnt_q;
    assign tap_xor        = kernel_aligned[TAPS-1] ^ bus.data_in;
    assign mism_total     = mism_q + CNT_W'(tap_xor);
    assign twice_mism     = {mism_total, 1'b0};
    assign last_tap       = (tap_cnt_q == CNT_W'(TAPS - 1));

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no path leaves it unassigned (no latches).
        state_d     = state_q;
        kernel_d    = kernel_q;
        tap_cnt_d   = tap_cnt_q;
        mism_d      = mism_q;
        addr_sh_d   = addr_sh_q;
        idx_sh_d    = idx_sh_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        neg_d       = neg_q;
        addr_out_d  = addr_out_q;
        idx_out_d   = idx_out_q;

        if (load_weight && tap_cnt_q == '0) begin
            kernel_d = {kernel_q[TAPS-2:0], weight_in};
        end

        if (clear) begin
            state_d     = IDLE;
            tap_cnt_d   = '0;
            mism_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                unique case (state_q)
                    IDLE: begin
                        addr_sh_d = bus.write_addr_in;
                        idx_sh_d  = bus.idx_in;
                        mism_d    = mism_total;
                        tap_cnt_d = CNT_W'(1);
                        state_d   = ACCUM;
                    end
                    ACCUM: begin
                        if (last_tap) begin
                            sum_d       = SUM_W'(TAPS) - twice_mism;
                            neg_d       = (twice_mism > SUM_W'(TAPS));
                            addr_out_d  = addr_sh_q;
                            idx_out_d   = idx_sh_q;
                            out_valid_d = 1'b1;
                            tap_cnt_d   = '0;
                            mism_d      = '0;
                            state_d     = IDLE;
                        end else begin
                            mism_d    = mism_total;
                            tap_cnt_d = tap_cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            kernel_q    <= '0;
            tap_cnt_q   <= '0;
            mism_q      <= '0;
            addr_sh_q   <= '0;
            idx_sh_q    <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            neg_q       <= 1'b0;
            addr_out_q  <= '0;
            idx_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            kernel_q    <= kernel_d;
            tap_cnt_q   <= tap_cnt_d;
            mism_q      <= mism_d;
            addr_sh_q   <= addr_sh_d;
            idx_sh_q    <= idx_sh_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            neg_q       <= neg_d;
            addr_out_q  <= addr_out_d;
            idx_out_q   <= idx_out_d;
        end
    end

endmodule

// File: tb/tb_bin_conv_pe.sv
// Self-checking bench for bin_conv_pe: a TAPS=9 and a TAPS=4 instance, table vectors,
// hand-written stall/go/clear/reset sequences and random windows against a dot-product model.
module tb_bin_conv_pe;

    localparam int ADDR_W = 12;
    localparam int IDX_W  = 4;
    localparam int SW9    = $clog2(9 + 1) + 1;
    localparam int SW4    = $clog2(4 + 1) + 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, go, clear, load_weight, weight_in;
    logic reset4, go4, clear4, load4, w4;

    bin_conv_pe_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .SUM_W(SW9)) b9 ();
    bin_conv_pe_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .SUM_W(SW4)) b4 ();

    bin_conv_pe #(.TAPS(9), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut9 (
        .clock(clock), .reset(reset), .go(go), .clear(clear),
        .load_weight(load_weight), .weight_in(weight_in), .bus(b9)
    );

    bin_conv_pe #(.TAPS(4), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut4 (
        .clock(clock), .reset(reset4), .go(go4), .clear(clear4),
        .load_weight(load4), .weight_in(w4), .bus(b4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: in_ready stayed low past the cycle budget, expected high", name);
    endtask

    // Model: kernel is the list of the last TAPS loaded bits, oldest pairs with tap 0.
    typedef bit bitq_t[$];
    bitq_t kq9, kq4;

    function automatic int dot(input bitq_t w, input logic [63:0] d, input int taps);
        int s = 0;
        for (int t = 0; t < taps; t++) s += (w[t] == d[t]) ? 1 : -1;
        return s;
    endfunction

    task automatic load9(input logic [8:0] w);
        for (int t = 0; t < 9; t++) begin
            load_weight = 1'b1;
            weight_in   = w[t];
            kq9.push_back(w[t]);
            void'(kq9.pop_front());
            @(negedge clock);
        end
        load_weight = 1'b0;
    endtask

    task automatic load4_k(input logic [3:0] w);
        for (int t = 0; t < 4; t++) begin
            load4 = 1'b1;
            w4    = w[t];
            kq4.push_back(w[t]);
            void'(kq4.pop_front());
            @(negedge clock);
        end
        load4 = 1'b0;
    endtask

    // Streams one 9-tap window; pause_at >= 0 drops go for 3 cycles before that tap and
    // pulses load_weight meanwhile (must be ignored mid-window).
    task automatic stream9(input logic [8:0] d, input logic [11:0] a, input logic [3:0] ix,
                           input int pause_at);
        int budget;
        for (int t = 0; t < 9; t++) begin
            b9.in_valid      = 1'b1;
            b9.data_in       = d[t];
            b9.write_addr_in = (t == 0) ? a : 12'($urandom);
            b9.idx_in        = (t == 0) ? ix : 4'($urandom);
            if (t == pause_at) begin
                go = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    load_weight = 1'b1;
                    weight_in   = 1'($urandom);
                    #1 check("go_low_in_ready", b9.in_ready, 0);
                    @(negedge clock);
                end
                load_weight = 1'b0;
                go = 1'b1;
            end
            budget = 0;
            #1;
            while (!b9.in_ready) begin
                @(negedge clock);
                #1;
                budget++;
                if (budget > 200) begin
                    timeout_fail("stream9");
                    b9.in_valid = 1'b0;
                    return;
                end
            end
            @(negedge clock);
        end
        b9.in_valid = 1'b0;
    endtask

    task automatic stream4(input logic [3:0] d, input logic [11:0] a, input logic [3:0] ix,
                           input int from, input int upto);
        int budget;
        for (int t = from; t <= upto; t++) begin
            b4.in_valid      = 1'b1;
            b4.data_in       = d[t];
            b4.write_addr_in = (t == 0) ? a : 12'($urandom);
            b4.idx_in        = (t == 0) ? ix : 4'($urandom);
            budget = 0;
            #1;
            while (!b4.in_ready) begin
                @(negedge clock);
                #1;
                budget++;
                if (budget > 200) begin
                    timeout_fail("stream4");
                    b4.in_valid = 1'b0;
                    return;
                end
            end
            @(negedge clock);
        end
        b4.in_valid = 1'b0;
    endtask

    task automatic expect9(input string tag, input int s, input logic [11:0] a, input logic [3:0] ix);
        check({tag, "_out_valid"}, b9.out_valid, 1);
        check({tag, "_sum"}, int'($signed(b9.sum_out)), s);
        check({tag, "_neg"}, b9.negative_flag, int'(s < 0));
        check({tag, "_addr"}, b9.write_addr_out, a);
        check({tag, "_idx"}, b9.idx_out, ix);
    endtask

    task automatic expect4(input string tag, input int s, input logic [11:0] a, input logic [3:0] ix);
        check({tag, "_out_valid"}, b4.out_valid, 1);
        check({tag, "_sum"}, int'($signed(b4.sum_out)), s);
        check({tag, "_neg"}, b4.negative_flag, int'(s < 0));
        check({tag, "_addr"}, b4.write_addr_out, a);
        check({tag, "_idx"}, b4.idx_out, ix);
    endtask

    typedef struct {
        logic [8:0]  data;
        logic [11:0] addr;
        logic [3:0]  idx;
        int          exp_sum;
        logic        exp_neg;
        logic [4:0]  exp_raw;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected summary earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        logic [8:0]  d;
        logic [11:0] a, a1;
        logic [3:0]  ix, i1;
        int          s1, bad;

        // Kernel 1,0,1,0,... as bit t = weight of tap t.
        vecs[0] = '{9'h155, 12'h123, 4'd5,  9, 1'b0, 5'h09};
        vecs[1] = '{9'h0AA, 12'h456, 4'd9, -9, 1'b1, 5'h17};
        vecs[2] = '{9'h14A, 12'hABC, 4'd1, -1, 1'b1, 5'h1F};
        vecs[3] = '{9'h15A, 12'h7FF, 4'd15, 1, 1'b0, 5'h01};

        for (int t = 0; t < 9; t++) kq9.push_back(1'b0);
        for (int t = 0; t < 4; t++) kq4.push_back(1'b0);

        reset = 1'b0; reset4 = 1'b0;
        go = 1'b1; clear = 1'b0; load_weight = 1'b0; weight_in = 1'b0;
        go4 = 1'b1; clear4 = 1'b0; load4 = 1'b0; w4 = 1'b0;
        b9.in_valid = 1'b0; b9.data_in = 1'b0; b9.write_addr_in = '0; b9.idx_in = '0; b9.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.data_in = 1'b0; b4.write_addr_in = '0; b4.idx_in = '0; b4.out_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1; reset4 = 1'b1;
        @(negedge clock);

        check("rst_out_valid", b9.out_valid, 0);
        check("rst_sum", b9.sum_out, 0);
        check("rst_neg", b9.negative_flag, 0);
        check("rst_addr", b9.write_addr_out, 0);
        check("rst_idx", b9.idx_out, 0);
        check("rst_in_ready", b9.in_ready, 1);

        // Table vectors, streamed back to back.
        load9(9'h155);
        for (int i = 0; i < 4; i++) begin
            stream9(vecs[i].data, vecs[i].addr, vecs[i].idx, -1);
            expect9($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].addr, vecs[i].idx);
            check($sformatf("vec%0d_neg_tab", i), b9.negative_flag, vecs[i].exp_neg);
            check($sformatf("vec%0d_raw", i), b9.sum_out, vecs[i].exp_raw);
        end
        @(negedge clock);
        check("handoff_drop_valid", b9.out_valid, 0);
        check("handoff_hold_sum", b9.sum_out, 5'h01);

        // Backpressure: first result stalls while a second window waits.
        a1 = 12'h321; i1 = 4'd3; d = 9'h1F0;
        s1 = dot(kq9, d, 9);
        stream9(d, a1, i1, -1);
        b9.out_ready = 1'b0;
        expect9("bp_first", s1, a1, i1);
        d = 9'h0F3; a = 12'h654; ix = 4'd7;
        bad = 0;
        fork
            stream9(d, a, ix, -1);
            begin
                for (int c = 0; c < 10; c++) begin
                    #2;
                    if (b9.in_ready !== 1'b0 || b9.out_valid !== 1'b1 ||
                        int'($signed(b9.sum_out)) != s1 || b9.write_addr_out !== a1 || b9.idx_out !== i1)
                        bad++;
                    @(negedge clock);
                end
                check("bp_stall_errors", bad, 0);
                b9.out_ready = 1'b1;
                #1 check("bp_release_in_ready", b9.in_ready, 1);
            end
        join
        expect9("bp_second", dot(kq9, d, 9), a, ix);

        // go low mid-window with load pulses: result equals the uninterrupted one.
        d = 9'h0C9; a = 12'h0AB; ix = 4'd12;
        stream9(d, a, ix, 5);
        expect9("go_pause", dot(kq9, d, 9), a, ix);

        // clear at tap 6, then a fresh window with its own sideband.
        for (int t = 0; t < 6; t++) begin
            b9.in_valid = 1'b1; b9.data_in = 1'($urandom);
            b9.write_addr_in = 12'hEEE; b9.idx_in = 4'd14;
            @(negedge clock);
        end
        clear = 1'b1;
        #1 check("clear_in_ready", b9.in_ready, 0);
        @(negedge clock);
        clear = 1'b0; b9.in_valid = 1'b0;
        check("clear_no_valid", b9.out_valid, 0);
        d = 9'h13C; a = 12'h777; ix = 4'd6;
        stream9(d, a, ix, -1);
        expect9("post_clear", dot(kq9, d, 9), a, ix);

        // clear also drops a pending result but keeps the data outputs.
        s1 = dot(kq9, d, 9);
        b9.out_ready = 1'b0;
        @(negedge clock);
        check("pend_hold_valid", b9.out_valid, 1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("pend_clear_valid", b9.out_valid, 0);
        check("pend_clear_sum", int'($signed(b9.sum_out)), s1);
        check("pend_clear_addr", b9.write_addr_out, a);
        b9.out_ready = 1'b1;

        // Random windows, occasional kernel reload with go low.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                go = 1'b0;
                load9(9'($urandom));
                go = 1'b1;
            end
            d = 9'($urandom); a = 12'($urandom); ix = 4'($urandom);
            stream9(d, a, ix, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 8)));
            expect9($sformatf("rand%0d", r), dot(kq9, d, 9), a, ix);
        end

        // TAPS=4: weights 1,1,0,0.
        load4_k(4'b0011);
        stream4(4'b0110, 12'h0F0, 4'd2, 0, 3);
        expect4("t4_zero", 0, 12'h0F0, 4'd2);
        stream4(4'b1100, 12'h00F, 4'd4, 0, 3);
        expect4("t4_min", -4, 12'h00F, 4'd4);

        // Async reset between edges in the middle of a window.
        stream4(4'b0101, 12'h111, 4'd8, 0, 1);
        #2 reset4 = 1'b0;
        #1;
        check("arst_out_valid", b4.out_valid, 0);
        check("arst_sum", b4.sum_out, 0);
        check("arst_neg", b4.negative_flag, 0);
        check("arst_addr", b4.write_addr_out, 0);
        check("arst_idx", b4.idx_out, 0);
        @(negedge clock);
        #2 reset4 = 1'b1;
        @(negedge clock);
        kq4.delete();
        for (int t = 0; t < 4; t++) kq4.push_back(1'b0);
        stream4(4'b0111, 12'h222, 4'd10, 0, 1);
        check("arst_partial_no_valid", b4.out_valid, 0);
        stream4(4'b0111, 12'h222, 4'd10, 2, 3);
        expect4("arst_fresh", dot(kq4, 4'b0111, 4), 12'h222, 4'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
